// File: rtl/uart_pkg.sv
// Shared types and derived constants for the FIFO-backed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Clocks per bit on the line.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Counter only ever holds DIV-1, so $clog2(DIV) bits are enough.
    function automatic int unsigned calc_cnt_w(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         dout
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign level   = count;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: emptiness is defined by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame (5..9 data bits, optional parity, 1/2 stop)
// fed from an internal FIFO so bursts go out back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 27000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_parity_en,
    input  logic                          i_parity_odd,
    input  logic                          i_two_stop,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CNT_W = calc_cnt_w(DIV);
    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    tx_state_t         state,       state_n;
    logic [CNT_W-1:0]  baud_cnt,    baud_cnt_n;
    logic [DATA_W-1:0] shifter,     shifter_n;
    logic [BIT_W-1:0]  bit_idx,     bit_idx_n;
    logic              par_bit,     par_bit_n;
    logic              cfg_par_en,  cfg_par_en_n;
    logic              cfg_two_stop, cfg_two_stop_n;
    logic              stop_second, stop_second_n;
    logic              tx_reg,      tx_n;
    logic              tick;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (i_valid),
        .din   (i_data),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_fifo_level),
        .dout  (fifo_dout)
    );

    assign o_ready   = ~fifo_full;
    assign o_uart_tx = tx_reg;
    assign o_busy    = (state != IDLE) | (o_fifo_level != '0);
    assign tick      = (baud_cnt == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            shifter      <= '0;
            bit_idx      <= '0;
            par_bit      <= 1'b0;
            cfg_par_en   <= 1'b0;
            cfg_two_stop <= 1'b0;
            stop_second  <= 1'b0;
            tx_reg       <= 1'b1;
        end else begin
            state        <= state_n;
            baud_cnt     <= baud_cnt_n;
            shifter      <= shifter_n;
            bit_idx      <= bit_idx_n;
            par_bit      <= par_bit_n;
            cfg_par_en   <= cfg_par_en_n;
            cfg_two_stop <= cfg_two_stop_n;
            stop_second  <= stop_second_n;
            tx_reg       <= tx_n;
        end
    end

    always_comb begin
        state_n        = state;
        baud_cnt_n     = tick ? baud_cnt : baud_cnt - 1'b1;
        shifter_n      = shifter;
        bit_idx_n      = bit_idx;
        par_bit_n      = par_bit;
        cfg_par_en_n   = cfg_par_en;
        cfg_two_stop_n = cfg_two_stop;
        stop_second_n  = stop_second;
        tx_n           = tx_reg;
        fifo_pop       = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                tx_n       = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_n    = DATA;
                    baud_cnt_n = DIV_M1;
                    tx_n       = shifter[0];
                    shifter_n  = shifter >> 1;
                    bit_idx_n  = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    baud_cnt_n = DIV_M1;
                    if (bit_idx == LAST_BIT) begin
                        stop_second_n = 1'b0;
                        if (cfg_par_en) begin
                            state_n = PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        tx_n      = shifter[0];
                        shifter_n = shifter >> 1;
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n       = STOP;
                    baud_cnt_n    = DIV_M1;
                    stop_second_n = 1'b0;
                    tx_n          = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    baud_cnt_n = DIV_M1;
                    if (cfg_two_stop && !stop_second) begin
                        stop_second_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Pop from IDLE or at the last stop-bit boundary, so queued words follow with no gap.
        if ((state == IDLE) || (state_n == IDLE && state == STOP)) begin
            if (!fifo_empty) begin
                fifo_pop       = 1'b1;
                state_n        = START;
                baud_cnt_n     = DIV_M1;
                shifter_n      = fifo_dout;
                par_bit_n      = (^fifo_dout) ^ i_parity_odd;
                cfg_par_en_n   = i_parity_en;
                cfg_two_stop_n = i_two_stop;
                stop_second_n  = 1'b0;
                tx_n           = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10, 8 data bits, 4-entry FIFO.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       par_en;
    logic       par_odd;
    logic       two_stop;
    logic       uart_tx;
    logic       busy;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo #(
        .CLK_FREQ_HZ (1000000),
        .BAUD_RATE   (100000),
        .DATA_W      (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (data),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_parity_en  (par_en),
        .i_parity_odd (par_odd),
        .i_two_stop   (two_stop),
        .o_uart_tx    (uart_tx),
        .o_busy       (busy),
        .o_fifo_level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at the negedge preceding the edge that writes the word.
    task automatic push_word(input logic [7:0] d);
        data  = d;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Called at the negedge just before the pop edge P; returns at the negedge
    // just before P + 10*nbits, i.e. where a back-to-back next frame would pop.
    task automatic check_frame(input logic [15:0] exp, input int nbits, input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_start_edge"}, 32'(uart_tx), 32'(1'b0));
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(uart_tx), 32'(exp[i]));
            if (i < nbits - 1) repeat (10) @(negedge clk);
            else               repeat (5) @(negedge clk);
        end
    endtask

    task automatic run_single(input logic [7:0] d, input logic pe, input logic po,
                              input logic ts, input logic [15:0] exp, input int nbits,
                              input string tag);
        par_en   = pe;
        par_odd  = po;
        two_stop = ts;
        push_word(d);
        check({tag, "_lvl_queued"}, 32'(level), 32'(1));
        check({tag, "_tx_idle_pre"}, 32'(uart_tx), 32'(1'b1));
        check_frame(exp, nbits, tag);
        check({tag, "_busy_last"}, 32'(busy), 32'(1'b1));
        @(negedge clk);
        check({tag, "_busy_done"}, 32'(busy), 32'(1'b0));
        check({tag, "_tx_done"}, 32'(uart_tx), 32'(1'b1));
    endtask

    initial begin
        rst = 1'b1; data = '0; valid = 1'b0;
        par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(uart_tx), 32'(1'b1));
        check("rst_ready", 32'(ready), 32'(1'b1));
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_level", 32'(level), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_tx", 32'(uart_tx), 32'(1'b1));

        // 8N1 0xA5 -> 0,1,0,1,0,0,1,0,1,1
        run_single(8'hA5, 1'b0, 1'b0, 1'b0, 16'h034A, 10, "n1_a5");
        // 8E1 0x07: parity 1
        run_single(8'h07, 1'b1, 1'b0, 1'b0, 16'h060E, 11, "e1_07");
        // 8O2 0x07: parity 0, two stop bits
        run_single(8'h07, 1'b1, 1'b1, 1'b1, 16'h0C0E, 12, "o2_07");
        par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
        repeat (3) @(negedge clk);

        // Burst of five, sixth ignored while full
        data = 8'h11; valid = 1'b1;
        fork
            begin
                @(posedge clk);
                @(negedge clk); data = 8'h22; @(posedge clk);
                @(negedge clk); data = 8'h33; @(posedge clk);
                @(negedge clk); data = 8'h44; @(posedge clk);
                @(negedge clk); data = 8'h55; @(posedge clk);
                @(negedge clk);
                check("burst_level_full", 32'(level), 32'(4));
                check("burst_ready_low", 32'(ready), 32'(1'b0));
                data = 8'h66;
                @(posedge clk);
                @(negedge clk);
                check("burst_full_ignore", 32'(level), 32'(4));
                valid = 1'b0;
            end
            begin
                @(posedge clk);
                @(negedge clk);
                check_frame(16'h0222, 10, "burst0");
                check_frame(16'h0244, 10, "burst1");
                check_frame(16'h0266, 10, "burst2");
                check_frame(16'h0288, 10, "burst3");
                check_frame(16'h02AA, 10, "burst4");
                @(negedge clk);
                check("burst_busy_done", 32'(busy), 32'(1'b0));
                check("burst_level_done", 32'(level), 32'(0));
            end
        join
        repeat (3) @(negedge clk);

        // Push on the exact pop edge at level 2
        data = 8'h81; valid = 1'b1;
        fork
            begin
                @(posedge clk);
                @(negedge clk); data = 8'h42; @(posedge clk);
                @(negedge clk); data = 8'hC3; @(posedge clk);
                @(negedge clk); valid = 1'b0;
                check("pp_level_pre", 32'(level), 32'(2));
                repeat (98) @(negedge clk);
                data = 8'h24; valid = 1'b1;
                @(posedge clk);
                @(negedge clk);
                valid = 1'b0;
                check("pp_level_same", 32'(level), 32'(2));
            end
            begin
                @(posedge clk);
                @(negedge clk);
                check_frame(16'h0302, 10, "pp0");
                check_frame(16'h0284, 10, "pp1");
                check_frame(16'h0386, 10, "pp2");
                check_frame(16'h0248, 10, "pp3");
                @(negedge clk);
                check("pp_busy_done", 32'(busy), 32'(1'b0));
            end
        join
        repeat (3) @(negedge clk);

        // Reset during DATA bit 3 of 0x00 with one word still queued
        data = 8'h00; valid = 1'b1;
        @(posedge clk);
        @(negedge clk); data = 8'h55;
        @(posedge clk);
        @(negedge clk); valid = 1'b0;
        repeat (44) @(negedge clk);
        check("mid_tx_low", 32'(uart_tx), 32'(1'b0));
        check("mid_level", 32'(level), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", 32'(uart_tx), 32'(1'b1));
        check("async_rst_level", 32'(level), 32'(0));
        check("async_rst_ready", 32'(ready), 32'(1'b1));
        check("async_rst_busy", 32'(busy), 32'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_single(8'h3C, 1'b0, 1'b0, 1'b0, 16'h0278, 10, "after_rst_3c");
        repeat (3) @(negedge clk);

        // Enabling parity mid-frame only affects the next frame
        data = 8'h07; valid = 1'b1;
        fork
            begin
                @(posedge clk);
                @(negedge clk);
                @(posedge clk);
                @(negedge clk); valid = 1'b0;
                repeat (23) @(negedge clk);
                par_en = 1'b1;
            end
            begin
                @(posedge clk);
                @(negedge clk);
                check_frame(16'h020E, 10, "cfg_nopar");
                check_frame(16'h060E, 11, "cfg_par");
                @(negedge clk);
                check("cfg_busy_done", 32'(busy), 32'(1'b0));
            end
        join
        par_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
